// File: rtl/arm_pipe_pkg.sv
// rtl/arm_pipe_pkg.sv - shared types and helpers for the pipeline hazard controller
// Contents:
//   fwd_sel_t   : operand select encoding for the E-stage operand muxes
//   stage_tag_t : per-stage destination tag carried alongside the pipeline
//   fwd_pick    : per-port forwarding priority (PC port never forwards, M beats W)
package arm_pipe_pkg;

    localparam int PC_REG_DEF = 15;

    // Widest register address a stage tag can carry; the top uses the low AW bits.
    localparam int TAG_AW_MAX = 8;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic                  valid;
        logic [TAG_AW_MAX-1:0] wa;
        logic                  regwrite;
        logic                  memtoreg;
        logic                  pcsrc;
    } stage_tag_t;

    function automatic fwd_sel_t fwd_pick(input logic use_i, input logic is_pc,
                                          input logic hit_m, input logic hit_w);
        if (!use_i || is_pc) return FWD_RF;
        if (hit_m) return FWD_MEM;
        if (hit_w) return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - decode/execute/memory control bundle of the hazard controller
// Signals:
//   rad_d/use_d/wa_d/regwrite_d/memtoreg_d/pcsrc_d : decode instruction fields
//   cond_pass_e/branch_taken_e                    : execute-stage resolution
//   mem_req_m/mem_ready                           : memory access handshake
//   stall_*/flush_*/fwd_sel_e/*_cnt               : controller outputs
// Modports: master drives the pipeline inputs, slave is the hazard controller.
interface pipe_hazard_ctrl_if #(
    parameter int AW    = 4,
    parameter int NRD   = 3,
    parameter int CNT_W = 16
);
    logic [NRD*AW-1:0] rad_d;
    logic [NRD-1:0]    use_d;
    logic [AW-1:0]     wa_d;
    logic              regwrite_d;
    logic              memtoreg_d;
    logic              pcsrc_d;
    logic              cond_pass_e;
    logic              branch_taken_e;
    logic              mem_req_m;
    logic              mem_ready;

    logic              stall_f;
    logic              stall_d;
    logic              stall_e;
    logic              stall_m;
    logic              flush_d;
    logic              flush_e;
    logic [NRD*2-1:0]  fwd_sel_e;
    logic [CNT_W-1:0]  ldr_stall_cnt;
    logic [CNT_W-1:0]  mem_stall_cnt;

    modport master (
        output rad_d, use_d, wa_d, regwrite_d, memtoreg_d, pcsrc_d,
               cond_pass_e, branch_taken_e, mem_req_m, mem_ready,
        input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
               fwd_sel_e, ldr_stall_cnt, mem_stall_cnt
    );

    modport slave (
        input  rad_d, use_d, wa_d, regwrite_d, memtoreg_d, pcsrc_d,
               cond_pass_e, branch_taken_e, mem_req_m, mem_ready,
        output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
               fwd_sel_e, ldr_stall_cnt, mem_stall_cnt
    );

endinterface

// File: rtl/hazard_tag_reg.sv
// rtl/hazard_tag_reg.sv - pipeline tag register with hold and bubble controls
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears to an invalid tag)
//   i_hold     : keep the current contents (wins over i_bubble)
//   i_bubble   : load all zeros, i.e. an invalid tag
//   i_d / o_q  : next tag / current tag
module hazard_tag_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_hold,
    input  logic         i_bubble,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (!i_hold) begin
            r_q <= i_bubble ? '0 : i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/forwarding controller for the 5-stage pipeline
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : pipe_hazard_ctrl_if slave (decode fields, E resolution, memory
//           handshake in; stalls, flushes, operand selects, counters out)
// The controller tracks the destination of the instructions in E, M and W
// with its own tag registers, so every hazard decision needs only the decode
// fields and the E/M handshake inputs of the current cycle.
module pipe_hazard_ctrl
    import arm_pipe_pkg::*;
#(
    parameter int AW     = 4,
    parameter int NRD    = 3,
    parameter int PC_REG = PC_REG_DEF,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int              TW    = $bits(stage_tag_t);
    localparam int              EW    = TW + NRD*AW + NRD;
    localparam logic [AW-1:0]   LP_PC = AW'(PC_REG);

    stage_tag_t        w_d_tag;
    stage_tag_t        w_e_tag;
    stage_tag_t        w_m_d;
    stage_tag_t        w_m_tag;
    stage_tag_t        w_w_tag;
    logic [EW-1:0]     w_e_d;
    logic [EW-1:0]     w_e_q;
    logic [NRD*AW-1:0] w_e_ra;
    logic [NRD-1:0]    w_e_use;

    logic              w_mem_stall;
    logic              w_ldr_hit;
    logic              w_ldr_stall;
    logic              w_pcwr_pend;
    logic              w_m_wr;
    logic              w_w_wr;
    logic [NRD*2-1:0]  w_fwd;
    logic              w_unused;

    logic [CNT_W-1:0]  r_ldr_cnt;
    logic [CNT_W-1:0]  r_mem_cnt;

    // Decode fields packed as the incoming E tag.
    always_comb begin
        w_d_tag              = '0;
        w_d_tag.valid        = 1'b1;
        w_d_tag.wa[AW-1:0]   = bus.wa_d;
        w_d_tag.regwrite     = bus.regwrite_d;
        w_d_tag.memtoreg     = bus.memtoreg_d;
        w_d_tag.pcsrc        = bus.pcsrc_d;
    end

    assign w_e_d   = {w_d_tag, bus.rad_d, bus.use_d};
    assign w_e_tag = w_e_q[EW-1 -: TW];
    assign w_e_ra  = w_e_q[NRD +: NRD*AW];
    assign w_e_use = w_e_q[NRD-1:0];

    // A failed condition turns the instruction leaving E into a no-op for
    // everything downstream: it neither writes a register nor redirects the PC.
    always_comb begin
        w_m_d          = w_e_tag;
        w_m_d.regwrite = w_e_tag.regwrite & bus.cond_pass_e;
        w_m_d.pcsrc    = w_e_tag.pcsrc & bus.cond_pass_e;
    end

    hazard_tag_reg #(.W(EW)) u_tag_e (
        .clk      (clk),
        .rst_n    (reset),
        .i_hold   (w_mem_stall),
        .i_bubble (bus.flush_e),
        .i_d      (w_e_d),
        .o_q      (w_e_q)
    );

    hazard_tag_reg #(.W(TW)) u_tag_m (
        .clk      (clk),
        .rst_n    (reset),
        .i_hold   (w_mem_stall),
        .i_bubble (1'b0),
        .i_d      (w_m_d),
        .o_q      (w_m_tag)
    );

    // W keeps advancing during a memory wait, so it drains and then fills with bubbles.
    hazard_tag_reg #(.W(TW)) u_tag_w (
        .clk      (clk),
        .rst_n    (reset),
        .i_hold   (1'b0),
        .i_bubble (w_mem_stall),
        .i_d      (w_m_tag),
        .o_q      (w_w_tag)
    );

    assign w_mem_stall = w_m_tag.valid & bus.mem_req_m & ~bus.mem_ready;

    always_comb begin
        w_ldr_hit = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            if (bus.use_d[i] && (bus.rad_d[i*AW +: AW] == w_e_tag.wa[AW-1:0])) begin
                w_ldr_hit = 1'b1;
            end
        end
    end

    assign w_ldr_stall = w_e_tag.valid & w_e_tag.memtoreg & w_e_tag.regwrite & w_ldr_hit;
    assign w_pcwr_pend = bus.pcsrc_d | (w_e_tag.valid & w_e_tag.pcsrc)
                                     | (w_m_tag.valid & w_m_tag.pcsrc);

    assign bus.stall_f = w_mem_stall | w_ldr_stall | w_pcwr_pend;
    assign bus.stall_d = w_mem_stall | w_ldr_stall;
    assign bus.stall_e = w_mem_stall;
    assign bus.stall_m = w_mem_stall;
    assign bus.flush_e = ~w_mem_stall & (w_ldr_stall | bus.branch_taken_e);
    // A D instruction held behind a load-use stall must survive a pending PC
    // write; only a taken branch may discard it.
    assign bus.flush_d = ~w_mem_stall & (bus.branch_taken_e |
                         ((w_pcwr_pend | (w_w_tag.valid & w_w_tag.pcsrc)) & ~w_ldr_stall));

    assign w_m_wr = w_m_tag.valid & w_m_tag.regwrite;
    assign w_w_wr = w_w_tag.valid & w_w_tag.regwrite;

    always_comb begin
        w_fwd = '0;
        for (int i = 0; i < NRD; i++) begin
            w_fwd[i*2 +: 2] = fwd_pick(w_e_use[i],
                                       w_e_ra[i*AW +: AW] == LP_PC,
                                       w_m_wr && (w_m_tag.wa[AW-1:0] == w_e_ra[i*AW +: AW]),
                                       w_w_wr && (w_w_tag.wa[AW-1:0] == w_e_ra[i*AW +: AW]));
        end
    end

    assign bus.fwd_sel_e = w_fwd;

    // A frozen pipe is charged to the memory counter only, even when a
    // load-use condition is also visible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ldr_cnt <= '0;
            r_mem_cnt <= '0;
        end else begin
            if (w_mem_stall && (r_mem_cnt != '1)) begin
                r_mem_cnt <= r_mem_cnt + CNT_W'(1);
            end
            if (w_ldr_stall && !w_mem_stall && (r_ldr_cnt != '1)) begin
                r_ldr_cnt <= r_ldr_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.ldr_stall_cnt = r_ldr_cnt;
    assign bus.mem_stall_cnt = r_mem_cnt;

    assign w_unused = ^{w_w_tag.memtoreg, w_w_tag.wa};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam int AW    = 4;
    localparam int NRD   = 3;
    localparam int PCR   = 15;
    localparam int CNT_W = 5;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.AW(AW), .NRD(NRD), .CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(.AW(AW), .NRD(NRD), .PC_REG(PCR), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference pipeline: index 0 = E, 1 = M, 2 = W.
    bit sv[3];
    int swa[3];
    bit srw[3];
    bit smt[3];
    bit spc[3];
    int era[NRD];
    bit euse[NRD];
    int m_ldr, m_mem;

    bit               e_mem, e_ldr, e_pend;
    logic [5:0]       e_ctl;   // stall_f, stall_d, stall_e, stall_m, flush_d, flush_e
    logic [2*NRD-1:0] e_fwd;
    logic [5:0]       act_ctl;

    assign act_ctl = {bus.stall_f, bus.stall_d, bus.stall_e, bus.stall_m, bus.flush_d, bus.flush_e};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_stage(input int k);
        sv[k] = 0; swa[k] = 0; srw[k] = 0; smt[k] = 0; spc[k] = 0;
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++) clear_stage(k);
        for (int i = 0; i < NRD; i++) begin era[i] = 0; euse[i] = 0; end
        m_ldr = 0;
        m_mem = 0;
    endtask

    task automatic model_eval();
        bit br, fd, fe;
        int ra;
        br    = bus.branch_taken_e;
        e_mem = sv[1] && bus.mem_req_m && !bus.mem_ready;
        e_ldr = 0;
        if (sv[0] && smt[0] && srw[0])
            for (int i = 0; i < NRD; i++)
                if (bus.use_d[i] && int'(bus.rad_d[i*AW +: AW]) == swa[0]) e_ldr = 1;
        e_pend = bus.pcsrc_d || (sv[0] && spc[0]) || (sv[1] && spc[1]);
        fe = !e_mem && (e_ldr || br);
        fd = !e_mem && (br || ((e_pend || (sv[2] && spc[2])) && !e_ldr));
        e_ctl = {e_mem || e_ldr || e_pend, e_mem || e_ldr, e_mem, e_mem, fd, fe};
        for (int i = 0; i < NRD; i++) begin
            ra = era[i];
            e_fwd[i*2 +: 2] = 2'b00;
            if (euse[i] && ra != PCR) begin
                if (sv[1] && srw[1] && swa[1] == ra)      e_fwd[i*2 +: 2] = 2'b10;
                else if (sv[2] && srw[2] && swa[2] == ra) e_fwd[i*2 +: 2] = 2'b01;
            end
        end
    endtask

    task automatic model_advance();
        if (e_mem) begin
            if (m_mem < CMAX) m_mem++;
            clear_stage(2);
        end else begin
            if (e_ldr && m_ldr < CMAX) m_ldr++;
            sv[2] = sv[1]; swa[2] = swa[1]; srw[2] = srw[1]; smt[2] = smt[1]; spc[2] = spc[1];
            sv[1] = sv[0]; swa[1] = swa[0]; smt[1] = smt[0];
            srw[1] = srw[0] && bus.cond_pass_e;
            spc[1] = spc[0] && bus.cond_pass_e;
            if (e_ctl[0]) begin
                clear_stage(0);
                for (int i = 0; i < NRD; i++) begin era[i] = 0; euse[i] = 0; end
            end else begin
                sv[0] = 1; swa[0] = int'(bus.wa_d); srw[0] = bus.regwrite_d;
                smt[0] = bus.memtoreg_d; spc[0] = bus.pcsrc_d;
                for (int i = 0; i < NRD; i++) begin
                    era[i]  = int'(bus.rad_d[i*AW +: AW]);
                    euse[i] = bus.use_d[i];
                end
            end
        end
    endtask

    task automatic idle();
        bus.rad_d = '0; bus.use_d = '0; bus.wa_d = '0;
        bus.regwrite_d = 0; bus.memtoreg_d = 0; bus.pcsrc_d = 0;
        bus.cond_pass_e = 1; bus.branch_taken_e = 0;
        bus.mem_req_m = 0; bus.mem_ready = 1;
    endtask

    task automatic set_d(input int r0, input int r1, input int r2, input logic [2:0] u,
                         input int wa, input bit rw, input bit mt, input bit pc);
        idle();
        bus.rad_d = {AW'(r2), AW'(r1), AW'(r0)};
        bus.use_d = u;
        bus.wa_d = AW'(wa);
        bus.regwrite_d = rw; bus.memtoreg_d = mt; bus.pcsrc_d = pc;
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
        chk("ctl", 32'(act_ctl), 32'(e_ctl));
        chk("fwd", 32'(bus.fwd_sel_e), 32'(e_fwd));
        chk("ldr_cnt", 32'(bus.ldr_stall_cnt), m_ldr);
        chk("mem_cnt", 32'(bus.mem_stall_cnt), m_mem);
    endtask

    task automatic advance();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    // Asynchronous reset from any point in the cycle; checked before the next edge.
    task automatic reset_now();
        idle();
        reset = 0;
        #1;
        chk("rst_ctl", 32'(act_ctl), 0);
        chk("rst_fwd", 32'(bus.fwd_sel_e), 0);
        chk("rst_cnt", 32'({bus.ldr_stall_cnt, bus.mem_stall_cnt}), 0);
        model_clear();
        @(posedge clk);
        #1;
        reset = 1;
    endtask

    task automatic rand_inputs();
        int r;
        for (int i = 0; i < NRD; i++) begin
            r = ($urandom_range(0, 9) == 0) ? PCR : int'($urandom_range(0, 3));
            bus.rad_d[i*AW +: AW] = AW'(r);
        end
        bus.use_d          = NRD'($urandom);
        bus.wa_d           = ($urandom_range(0, 9) == 0) ? AW'(PCR) : AW'($urandom_range(0, 3));
        bus.regwrite_d     = ($urandom_range(0, 3) != 0);
        bus.memtoreg_d     = ($urandom_range(0, 2) == 0);
        bus.pcsrc_d        = ($urandom_range(0, 15) == 0);
        bus.cond_pass_e    = ($urandom_range(0, 3) != 0);
        bus.branch_taken_e = ($urandom_range(0, 9) == 0);
        bus.mem_req_m      = $urandom_range(0, 1) == 1;
        bus.mem_ready      = $urandom_range(0, 1) == 1;
    endtask

    initial begin
        idle();
        model_clear();
        #2;
        reset_now();

        // Load-use: LDR r3 then a reader of r3 on port 1.
        set_d(0, 0, 0, 3'b000, 3, 1, 1, 0); settle(); advance();
        set_d(0, 3, 0, 3'b010, 4, 1, 0, 0); settle();
        chk("lu_stall", 32'({bus.stall_f, bus.stall_d, bus.flush_e, bus.flush_d}), 32'(4'b1110));
        advance();
        settle();
        chk("lu_release", 32'({bus.stall_d, bus.flush_e}), 0);
        chk("lu_cnt", 32'(bus.ldr_stall_cnt), 1);
        advance();
        idle(); settle();
        chk("lu_fwd", 32'(bus.fwd_sel_e[3:2]), 1);
        advance();

        // Back-to-back writers of r2; second writer optionally fails its condition.
        for (int v = 0; v < 2; v++) begin
            reset_now();
            set_d(0, 0, 0, 3'b000, 2, 1, 0, 0); settle(); advance();
            set_d(0, 0, 0, 3'b000, 2, 1, 0, 0); settle(); advance();
            set_d(2, 0, 0, 3'b001, 5, 1, 0, 0); bus.cond_pass_e = (v == 0); settle(); advance();
            idle(); settle();
            chk("fwd_mw", 32'(bus.fwd_sel_e[1:0]), (v == 0) ? 2 : 1);
            advance();
        end

        // Memory wait of 3 cycles with a taken branch held in E throughout.
        reset_now();
        set_d(0, 0, 0, 3'b000, 5, 1, 1, 0); settle(); advance();
        idle(); settle(); advance();
        for (int c = 0; c < 3; c++) begin
            idle(); bus.mem_req_m = 1; bus.mem_ready = 0; bus.branch_taken_e = 1;
            settle();
            chk("mw_stall", 32'({bus.stall_f, bus.stall_d, bus.stall_e, bus.stall_m}), 32'(4'b1111));
            chk("mw_noflush", 32'({bus.flush_d, bus.flush_e}), 0);
            advance();
        end
        idle(); bus.mem_req_m = 1; bus.mem_ready = 1; bus.branch_taken_e = 1;
        settle();
        chk("mw_release_flush", 32'({bus.flush_d, bus.flush_e}), 32'(2'b11));
        chk("mw_cnt", 32'(bus.mem_stall_cnt), 3);
        advance();

        // PC write travelling D, E, M, W; condition fails in E when v==1.
        for (int v = 0; v < 2; v++) begin
            reset_now();
            set_d(0, 0, 0, 3'b000, PCR, 1, 0, 1); settle();
            chk("pc_d", 32'({bus.stall_f, bus.flush_d}), 32'(2'b11));
            advance();
            idle(); bus.cond_pass_e = (v == 0); settle();
            chk("pc_e", 32'({bus.stall_f, bus.flush_d}), 32'(2'b11));
            advance();
            idle(); settle();
            chk("pc_m", 32'({bus.stall_f, bus.flush_d}), (v == 0) ? 3 : 0);
            advance();
            idle(); settle();
            chk("pc_w", 32'({bus.stall_f, bus.flush_d}), (v == 0) ? 1 : 0);
            advance();
            idle(); settle();
            chk("pc_done", 32'({bus.stall_f, bus.flush_d}), 0);
            advance();
        end

        // Reset in the middle of a memory freeze.
        reset_now();
        set_d(0, 0, 0, 3'b000, 6, 1, 1, 0); settle(); advance();
        idle(); settle(); advance();
        idle(); bus.mem_req_m = 1; bus.mem_ready = 0; settle(); advance();
        idle(); bus.mem_req_m = 1; bus.mem_ready = 0; settle();
        chk("rs_pre", 32'({bus.stall_m, bus.mem_stall_cnt}), 32'({1'b1, CNT_W'(1)}));
        #2;
        reset_now();
        idle(); bus.mem_req_m = 1; bus.mem_ready = 0; settle();
        chk("rs_empty", 32'(act_ctl), 0);
        advance();

        // Randomized traffic, long enough to saturate the narrow counters.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) reset_now();
            rand_inputs();
            settle();
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised hazard and forwarding controller for the 5-stage pipeline (F/D/E/M/W). It replaces the purely combinational hazard unit with one that carries its own destination/source tags through E, M and W. Generalised to NRD source ports and a configurable PC register index. New capabilities: variable-latency memory stalls via a mem_req/mem_ready handshake, and saturating stall performance counters.

Parameters:
AW, 4, register-address width
NRD, 3, number of decode source-register ports
PC_REG, 15, register index whose write redirects the PC
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
rad_d  in  NRD*AW  decode source register addresses, port i at [i*AW +: AW]
use_d  in  NRD  port i source actually read by the decode instruction
wa_d  in  AW  decode destination register
regwrite_d  in  1  decode instruction writes the register file
memtoreg_d  in  1  decode instruction is a load
pcsrc_d  in  1  decode instruction writes PC_REG
cond_pass_e  in  1  condition check passed in E
branch_taken_e  in  1  branch resolved taken in E
mem_req_m  in  1  M stage holds a load/store
mem_ready  in  1  memory completes the M access this cycle
stall_f, stall_d, stall_e, stall_m  out  1 each  hold the pipeline register feeding that stage
flush_d, flush_e  out  1 each  clear the F/D register and the D/E register
fwd_sel_e  out  NRD*2  per-port operand select: 00 register file, 01 W result, 10 M ALU result
ldr_stall_cnt  out  CNT_W  saturating count of load-use stall cycles
mem_stall_cnt  out  CNT_W  saturating count of memory-wait cycles

Behaviour:
- Reset (reset=0, asynchronous): all stage tags invalid; both counters 0. With tags invalid and inputs idle, every stall/flush output is 0 and fwd_sel_e=0.
- Internal tag registers E, M and W each hold: valid, wa, regwrite, memtoreg, pcsrc. E also holds ra[NRD] and use[NRD].
  - D->E: load from the *_d inputs with valid=1. Load a bubble (valid=0) on flush_e. Hold on stall_e.
  - E->M: on advance, regwrite and pcsrc are ANDed with cond_pass_e. Hold on stall_m.
  - M->W: load from M. Load a bubble when mem_stall is active.
- mem_stall = M.valid & mem_req_m & ~mem_ready.
- ldr_stall = E.valid & E.memtoreg & E.regwrite & OR over i of (use_d[i] & rad_d[i]==E.wa).
- pcwr_pend = pcsrc_d | (E.valid & E.pcsrc) | (M.valid & M.pcsrc).
- Output equations:
  - stall_f = mem_stall | ldr_stall | pcwr_pend
  - stall_d = mem_stall | ldr_stall
  - stall_e = stall_m = mem_stall
  - flush_e = ~mem_stall & (ldr_stall | branch_taken_e)
  - flush_d = ~mem_stall & (branch_taken_e | ((pcwr_pend | (W.valid & W.pcsrc)) & ~ldr_stall))
- Priority: mem_stall overrides every flush, so a branch resolved while the pipe is frozen takes effect on the first cycle mem_ready=1. A flush_d never discards a D instruction that is being held by ldr_stall, except on branch_taken_e, where D is wrong-path anyway.
- Forwarding, per port i:
  - Select 10 when M.valid & M.regwrite & M.wa==E.ra[i] & E.use[i].
  - Otherwise select 01 when W.valid & W.regwrite & W.wa==E.ra[i] & E.use[i].
  - Otherwise select 00.
  - M has priority over W.
  - Never forward when E.ra[i]==PC_REG; the datapath supplies PC+8 for that port.
- Latency: a load-use costs exactly 1 bubble. Each mem_ready=0 cycle adds 1 full freeze cycle.
- Counters: each increments by 1 per cycle its cause is active and saturates at all-ones. A cycle where ldr_stall and mem_stall are both active counts only in mem_stall_cnt.
- Reset mid-stall: all tags and counters clear immediately; the next released cycle behaves as an empty pipe.

Decomposition:
- Shared package arm_pipe_pkg holds:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - stage_tag_t struct (valid, wa, regwrite, memtoreg, pcsrc)
  - PC_REG default constant
- One sub-module, hazard_tag_reg: a parametrised tag register with hold/bubble controls and async active-low reset, instantiated for E, M and W.

Test Plan:
- Load-use: LDR r3 (E), then ADD using r3 on port 1 in D. Required: one cycle with stall_f=stall_d=flush_e=1; the following cycle fwd_sel_e[3:2]=01; ldr_stall_cnt=1.
- Back-to-back ALU: r2 written by the M instruction and by the W instruction, read on port 0 in E. Required: fwd_sel_e[1:0]=10 (M wins). Same case with cond_pass_e=0 on the M instruction. Required: 01.
- Memory wait: mem_req_m=1 with mem_ready=0 for 3 cycles. Required: stall_f/d/e/m=1 for those 3 cycles with no flushes; W receives bubbles; mem_stall_cnt=3.
- Branch during freeze: branch_taken_e=1 while mem_stall is active. Required: flush_d=flush_e=0 until mem_ready=1, then both are 1 in that cycle.
- PC write: a D instruction with pcsrc_d=1. Required: stall_f=1 for 3 cycles (D, E, M) and flush_d=1 for 4 cycles including W; with cond_pass_e=0 the M/W pending terms drop.
- Async reset asserted mid-stall. Required: all outputs 0 in the same cycle and both counters 0.
